exec_mem_unit: RTL and testbench
================================

EXEC_MEM_UNIT -- requirements
Module: exec_mem_unit

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 12, address width; DATA_WIDTH, default 12, data word width; START_ADDRESS, default 12'o0200, PC value after reset.
REQ-002 SHALL have ports as follows (name  direction  width  meaning):
- clk  input  1  clock; all state updates on its rising edge.
- reset_n  input  1  reset, asynchronous, active-high.
- dec_valid  input  1  one-cycle pulse; decoded instruction fields are valid.
- base_addr  input  ADDR_WIDTH  address of the decoded instruction.
- pdp_mem_opcode  input  pdp_mem_opcode_s  memory-reference decode, with one-hot AND/TAD/ISZ/DCA/JMS/JMP and mem_inst_addr[8:0].
- pdp_op7_opcode  input  pdp_op7_opcode_s  group-1/2 operate decode, one-hot.
- stall  output  1  execution busy; IFD holds off fetching.
- PC_value  output  ADDR_WIDTH  next fetch address.
- exec_rd_req  output  1  memory read request.
- exec_rd_addr  output  ADDR_WIDTH  memory read address.
- exec_rd_data  input  DATA_WIDTH  read data, valid one cycle after exec_rd_req.
- exec_wr_req  output  1  memory write strobe.
- exec_wr_addr  output  ADDR_WIDTH  memory write address.
- exec_wr_data  output  DATA_WIDTH  memory write data.
- ac_out  output  DATA_WIDTH  accumulator, for observation.
- link_out  output  1  link bit.

Function
REQ-003 SHALL implement FSM states IDLE, CALC_EA, RD_IND, RD_DATA, EXEC, WR, HALT.
REQ-004 SHALL move IDLE->CALC_EA on dec_valid; stall SHALL go to 1 at the next clock edge and stay 1 until the edge that returns the FSM to IDLE.
REQ-005 SHALL form the effective address as follows: mem_inst_addr[7]=1 gives {base_addr[11:7], mem_inst_addr[6:0]}; otherwise it gives {5'b0, mem_inst_addr[6:0]}.
REQ-006 SHALL handle indirect mode (mem_inst_addr[8]=1) with one extra read in RD_IND: read M[EA], and that data becomes the EA. There is no auto-increment.
REQ-007 SHALL use the RD_DATA state only for AND/TAD/ISZ: exec_rd_req is high for exactly 1 cycle, and data is captured on the next cycle in EXEC.
REQ-008 SHALL execute the memory-reference instructions as follows:
- AND: AC&=M.
- TAD: {L,AC}=({L,AC}+M); the carry complements L.
- ISZ: write M+1, mod 2^12.
- DCA: write AC, then AC=0.
- JMS: write PC+1 at EA, then PC=EA+1.
- JMP: PC=EA; there is no memory access.
REQ-009 SHALL assert exec_wr_req for exactly one cycle in WR, with address and data stable in that cycle.
REQ-010 SHALL update PC as follows:
- Default: base_addr+1.
- ISZ with result 0: base_addr+2.
- All PC arithmetic wraps modulo 2^12 (7777->0000).
REQ-011 SHALL execute operate instructions in EXEC with no memory access:
- CLA1/CLA2: AC=0.
- CLL: L=0.
- CLA_CLL: both clears.
- CMA: AC=~AC.
- CML: L=~L.
- CIA: AC=-AC.
- IAC: {L,AC}+1.
- All other op7 codes: NOP (PC+1).
REQ-012 SHALL enter HALT on HLT with stall held at 1 permanently; only reset SHALL exit HALT.
REQ-013 SHALL ignore dec_valid while not in IDLE.
REQ-014 SHALL never assert exec_rd_req and exec_wr_req in the same cycle.
REQ-015 SHALL treat an all-zero decode (no one-hot bit set) as NOP.

Reset
REQ-016 SHALL, while reset_n=1 (asynchronously), force: state IDLE, stall=0, PC_value=START_ADDRESS, AC=0, L=0, all request strobes 0, and all address/data outputs 0.
REQ-017 SHALL abandon any in-flight access when reset asserts mid-operation; no write SHALL be issued after reset is released.

Structure
REQ-018 SHALL take the following from pdp8_pkg: pdp_mem_opcode_s, pdp_op7_opcode_s, ADDR_WIDTH, DATA_WIDTH, START_ADDRESS, and the opcode defines. The exec state enum SHALL be added to pdp8_pkg.
REQ-019 SHALL place EA formation (page/zero-page and indirect select) in the sub-module exec_ea_calc.

Verification
REQ-020 Reset test: reset_n=1 mid-RD_DATA -> immediately PC_value=0200, stall=0, no exec_wr_req afterwards.
REQ-021 TAD test: AC=7777, L=0, TAD direct with M[0050]=0001 (base 0200, mem_inst_addr=0'050) -> AC=0000, L=1, PC=0201, exactly 1 read.
REQ-022 ISZ test: M[0210]=7777, ISZ current-page 010 at base 0205 -> write 0000 to 0210, PC=0207.
REQ-023 Indirect JMS test: JMS I with M[0020]=0300 -> reads 0020, writes 0201 at 0300, PC=0301, stall 1 throughout.
REQ-024 Operate test: CLA_CLL then IAC -> AC=0001, L=0, no memory strobes; then HLT -> stall stays 1 for 100 cycles.
REQ-025 Busy test: dec_valid pulsed while in EXEC -> ignored; PC and AC unchanged by the extra pulse.

Source files
------------

// File: rtl/pdp8_pkg.sv
// Shared PDP-8 types and constants for the execute/memory stage.
package pdp8_pkg;

    localparam int unsigned ADDR_WIDTH = 12;
    localparam int unsigned DATA_WIDTH = 12;
    localparam logic [11:0] START_ADDRESS = 12'o0200;

    localparam logic [2:0] OP_AND = 3'o0;
    localparam logic [2:0] OP_TAD = 3'o1;
    localparam logic [2:0] OP_ISZ = 3'o2;
    localparam logic [2:0] OP_DCA = 3'o3;
    localparam logic [2:0] OP_JMS = 3'o4;
    localparam logic [2:0] OP_JMP = 3'o5;
    localparam logic [2:0] OP_IOT = 3'o6;
    localparam logic [2:0] OP_OPR = 3'o7;

    typedef struct packed {
        logic       op_and;
        logic       op_tad;
        logic       op_isz;
        logic       op_dca;
        logic       op_jms;
        logic       op_jmp;
        logic [8:0] mem_inst_addr;
    } pdp_mem_opcode_s;

    typedef struct packed {
        logic nop, iac, ral, rar, rtl, rtr, cml, cma, cia, cll, cla1;
        logic cla_cll, hlt, osr, skp, snl, szl, sza, sna, sma, spa, cla2;
    } pdp_op7_opcode_s;

    typedef enum logic [2:0] {
        IDLE, CALC_EA, RD_IND, RD_DATA, EXEC, WR, HALT
    } exec_state_e;

endpackage

// File: rtl/exec_ea_calc.sv
// Effective-address formation: zero page / current page select, or the
// pointer word fetched during an indirect cycle.
module exec_ea_calc #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 12
) (
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [8:0]            mem_inst_addr,
    input  logic                  use_ptr,
    input  logic [DATA_WIDTH-1:0] ptr_data,
    output logic [ADDR_WIDTH-1:0] ea,
    output logic                  indirect
);

    always_comb begin
        if (use_ptr) begin
            ea = ptr_data[ADDR_WIDTH-1:0];
        end else if (mem_inst_addr[7]) begin
            ea = {base_addr[ADDR_WIDTH-1:7], mem_inst_addr[6:0]};
        end else begin
            ea = {{(ADDR_WIDTH-7){1'b0}}, mem_inst_addr[6:0]};
        end
    end

    assign indirect = mem_inst_addr[8];

endmodule

// File: rtl/exec_mem_unit.sv
// PDP-8 execute stage: runs memory-reference and operate instructions,
// driving a single-port memory with one-cycle read latency.
module exec_mem_unit #(
    parameter int unsigned ADDR_WIDTH = pdp8_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = pdp8_pkg::DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] START_ADDRESS = pdp8_pkg::START_ADDRESS
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      dec_valid,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    input  pdp8_pkg::pdp_mem_opcode_s pdp_mem_opcode,
    input  pdp8_pkg::pdp_op7_opcode_s pdp_op7_opcode,
    output logic                      stall,
    output logic [ADDR_WIDTH-1:0]     PC_value,
    output logic                      exec_rd_req,
    output logic [ADDR_WIDTH-1:0]     exec_rd_addr,
    input  logic [DATA_WIDTH-1:0]     exec_rd_data,
    output logic                      exec_wr_req,
    output logic [ADDR_WIDTH-1:0]     exec_wr_addr,
    output logic [DATA_WIDTH-1:0]     exec_wr_data,
    output logic [DATA_WIDTH-1:0]     ac_out,
    output logic                      link_out
);

    import pdp8_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] TWO_A = ADDR_WIDTH'(2);
    localparam logic [DATA_WIDTH-1:0] ONE_D = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH:0]   ONE_L = (DATA_WIDTH+1)'(1);

    exec_state_e           state_q, state_d, after_ea;
    logic                  ind_phase_q, ind_phase_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d, ea_q, ea_d, pc_q, pc_d;
    pdp_mem_opcode_s       mem_q, mem_d;
    pdp_op7_opcode_s       op7_q, op7_d;
    logic [DATA_WIDTH-1:0] ac_q, ac_d, data_q, data_d;
    logic                  link_q, link_d;

    logic [ADDR_WIDTH-1:0] ea, pc_inc;
    logic                  indirect, is_mem, needs_data;
    logic [DATA_WIDTH:0]   tad_sum, iac_sum;

    exec_ea_calc #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ea_calc (
        .base_addr    (base_q),
        .mem_inst_addr(mem_q.mem_inst_addr),
        .use_ptr      (state_q == RD_IND),
        .ptr_data     (exec_rd_data),
        .ea           (ea),
        .indirect     (indirect)
    );

    assign is_mem     = mem_q.op_and | mem_q.op_tad | mem_q.op_isz |
                        mem_q.op_dca | mem_q.op_jms | mem_q.op_jmp;
    assign needs_data = mem_q.op_and | mem_q.op_tad | mem_q.op_isz;
    assign pc_inc     = base_q + ONE_A;
    assign tad_sum    = {1'b0, ac_q} + {1'b0, exec_rd_data};
    assign iac_sum    = {link_q, ac_q} + ONE_L;

    // JMP, operate and empty decodes all finish in EXEC without memory traffic.
    always_comb begin
        if (needs_data) begin
            after_ea = RD_DATA;
        end else if (mem_q.op_dca || mem_q.op_jms) begin
            after_ea = WR;
        end else begin
            after_ea = EXEC;
        end
    end

    always_comb begin
        state_d      = state_q;
        ind_phase_d  = ind_phase_q;
        base_d       = base_q;
        mem_d        = mem_q;
        op7_d        = op7_q;
        ea_d         = ea_q;
        pc_d         = pc_q;
        ac_d         = ac_q;
        link_d       = link_q;
        data_d       = data_q;
        exec_rd_req  = 1'b0;
        exec_rd_addr = '0;
        exec_wr_req  = 1'b0;
        exec_wr_addr = '0;
        exec_wr_data = '0;

        unique case (state_q)
            IDLE: begin
                if (dec_valid) begin
                    base_d  = base_addr;
                    mem_d   = pdp_mem_opcode;
                    op7_d   = pdp_op7_opcode;
                    state_d = CALC_EA;
                end
            end
            CALC_EA: begin
                ea_d = ea;
                if (is_mem && indirect) begin
                    ind_phase_d = 1'b0;
                    state_d     = RD_IND;
                end else begin
                    state_d = after_ea;
                end
            end
            // First cycle requests the pointer, second cycle latches it as the EA.
            RD_IND: begin
                if (!ind_phase_q) begin
                    exec_rd_req  = 1'b1;
                    exec_rd_addr = ea_q;
                    ind_phase_d  = 1'b1;
                end else begin
                    ea_d        = ea;
                    ind_phase_d = 1'b0;
                    state_d     = after_ea;
                end
            end
            RD_DATA: begin
                exec_rd_req  = 1'b1;
                exec_rd_addr = ea_q;
                state_d      = EXEC;
            end
            EXEC: begin
                pc_d    = pc_inc;
                state_d = IDLE;
                if (mem_q.op_and) begin
                    ac_d = ac_q & exec_rd_data;
                end else if (mem_q.op_tad) begin
                    ac_d   = tad_sum[DATA_WIDTH-1:0];
                    link_d = link_q ^ tad_sum[DATA_WIDTH];
                end else if (mem_q.op_isz) begin
                    data_d  = exec_rd_data + ONE_D;
                    state_d = WR;
                end else if (mem_q.op_jmp) begin
                    pc_d = ea_q;
                end else if (!is_mem) begin
                    unique case (1'b1)
                        op7_q.cla1, op7_q.cla2: ac_d = '0;
                        op7_q.cll:              link_d = 1'b0;
                        op7_q.cla_cll: begin
                            ac_d   = '0;
                            link_d = 1'b0;
                        end
                        op7_q.cma:              ac_d = ~ac_q;
                        op7_q.cml:              link_d = ~link_q;
                        op7_q.cia:              ac_d = -ac_q;
                        op7_q.iac:              {link_d, ac_d} = iac_sum;
                        op7_q.hlt:              state_d = HALT;
                        op7_q.nop, op7_q.ral, op7_q.rar, op7_q.rtl, op7_q.rtr,
                        op7_q.osr, op7_q.skp, op7_q.snl, op7_q.szl, op7_q.sza,
                        op7_q.sna, op7_q.sma, op7_q.spa: ;
                        default: ;
                    endcase
                end
            end
            WR: begin
                exec_wr_req  = 1'b1;
                exec_wr_addr = ea_q;
                state_d      = IDLE;
                if (mem_q.op_isz) begin
                    exec_wr_data = data_q;
                    pc_d         = (data_q == '0) ? base_q + TWO_A : pc_inc;
                end else if (mem_q.op_dca) begin
                    exec_wr_data = ac_q;
                    ac_d         = '0;
                    pc_d         = pc_inc;
                end else begin
                    exec_wr_data = DATA_WIDTH'(pc_inc);
                    pc_d         = ea_q + ONE_A;
                end
            end
            HALT: ;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q     <= IDLE;
            ind_phase_q <= 1'b0;
            base_q      <= '0;
            mem_q       <= '0;
            op7_q       <= '0;
            ea_q        <= '0;
            pc_q        <= START_ADDRESS;
            ac_q        <= '0;
            link_q      <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            ind_phase_q <= ind_phase_d;
            base_q      <= base_d;
            mem_q       <= mem_d;
            op7_q       <= op7_d;
            ea_q        <= ea_d;
            pc_q        <= pc_d;
            ac_q        <= ac_d;
            link_q      <= link_d;
            data_q      <= data_d;
        end
    end

    assign stall    = (state_q != IDLE);
    assign PC_value = pc_q;
    assign ac_out   = ac_q;
    assign link_out = link_q;

endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed bench for exec_mem_unit with a one-cycle-latency memory model.
module tb_exec_mem_unit;

    import pdp8_pkg::*;

    localparam pdp_op7_opcode_s O_CLA_CLL = '{cla_cll: 1'b1, default: 1'b0};
    localparam pdp_op7_opcode_s O_CMA     = '{cma: 1'b1, default: 1'b0};
    localparam pdp_op7_opcode_s O_IAC     = '{iac: 1'b1, default: 1'b0};
    localparam pdp_op7_opcode_s O_HLT     = '{hlt: 1'b1, default: 1'b0};

    logic            clk = 1'b0;
    logic            reset_n, dec_valid;
    logic [11:0]     base_addr;
    pdp_mem_opcode_s mem_op;
    pdp_op7_opcode_s op7_op;
    logic            stall, exec_rd_req, exec_wr_req, link_out;
    logic [11:0]     PC_value, exec_rd_addr, exec_rd_data, exec_wr_addr, exec_wr_data, ac_out;

    logic [11:0] mem [4096];
    logic        poke_en;
    logic [11:0] poke_addr, poke_data;
    int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
    logic [11:0] last_rd_addr, last_wr_addr, last_wr_data;
    logic        wr_stall;
    int          tests = 0, fails = 0;
    int          r0, w0, low;

    always #5 clk = ~clk;

    exec_mem_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .dec_valid     (dec_valid),
        .base_addr     (base_addr),
        .pdp_mem_opcode(mem_op),
        .pdp_op7_opcode(op7_op),
        .stall         (stall),
        .PC_value      (PC_value),
        .exec_rd_req   (exec_rd_req),
        .exec_rd_addr  (exec_rd_addr),
        .exec_rd_data  (exec_rd_data),
        .exec_wr_req   (exec_wr_req),
        .exec_wr_addr  (exec_wr_addr),
        .exec_wr_data  (exec_wr_data),
        .ac_out        (ac_out),
        .link_out      (link_out)
    );

    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        if (exec_rd_req) begin
            exec_rd_data <= mem[exec_rd_addr];
            last_rd_addr <= exec_rd_addr;
            rd_cnt       <= rd_cnt + 1;
        end
        if (exec_wr_req) begin
            mem[exec_wr_addr] <= exec_wr_data;
            last_wr_addr      <= exec_wr_addr;
            last_wr_data      <= exec_wr_data;
            wr_stall          <= stall;
            wr_cnt            <= wr_cnt + 1;
        end
        if (exec_rd_req && exec_wr_req) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
        end
    endtask

    function automatic pdp_mem_opcode_s mk_mem(input int k, input logic [8:0] a);
        pdp_mem_opcode_s m = '0;
        m.mem_inst_addr = a;
        case (k)
            0: m.op_and = 1'b1;
            1: m.op_tad = 1'b1;
            2: m.op_isz = 1'b1;
            3: m.op_dca = 1'b1;
            4: m.op_jms = 1'b1;
            5: m.op_jmp = 1'b1;
            default: ;
        endcase
        return m;
    endfunction

    task automatic poke(input logic [11:0] a, input logic [11:0] d);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        @(negedge clk);
        poke_en   = 1'b0;
    endtask

    // Called at a negedge; holds dec_valid for exactly one rising edge.
    task automatic issue(input logic [11:0] base, input pdp_mem_opcode_s m,
                         input pdp_op7_opcode_s o);
        dec_valid = 1'b1;
        base_addr = base;
        mem_op    = m;
        op7_op    = o;
        @(negedge clk);
        dec_valid = 1'b0;
        base_addr = '0;
        mem_op    = '0;
        op7_op    = '0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (stall === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, stall}, 32'd0);
    endtask

    task automatic run(input logic [11:0] base, input pdp_mem_opcode_s m,
                       input pdp_op7_opcode_s o, input string tag);
        issue(base, m, o);
        wait_idle(tag);
    endtask

    initial begin
        reset_n   = 1'b1;
        dec_valid = 1'b0;
        base_addr = '0;
        mem_op    = '0;
        op7_op    = '0;
        poke_en   = 1'b0;
        poke_addr = '0;
        poke_data = '0;
        repeat (2) @(negedge clk);

        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_pc", {20'b0, PC_value}, 32'o0200);
        check("rst_ac", {20'b0, ac_out}, 32'd0);
        check("rst_link", {31'b0, link_out}, 32'd0);
        check("rst_strobes", {30'b0, exec_rd_req, exec_wr_req}, 32'd0);
        check("rst_addr_data", {exec_rd_addr, exec_wr_addr, exec_wr_data[7:0]}, 32'd0);
        reset_n = 1'b0;
        @(negedge clk);
        check("post_rst_pc", {20'b0, PC_value}, 32'o0200);

        // AC=7777, L=0, then TAD 0050 holding 0001 wraps AC and flips L
        run(12'o0200, '0, O_CLA_CLL, "idle_cla_cll");
        run(12'o0201, '0, O_CMA, "idle_cma");
        check("cma_ac", {20'b0, ac_out}, 32'o7777);
        poke(12'o0050, 12'o0001);
        r0 = rd_cnt; w0 = wr_cnt;
        run(12'o0200, mk_mem(1, 9'o050), '0, "idle_tad");
        check("tad_ac", {20'b0, ac_out}, 32'd0);
        check("tad_link", {31'b0, link_out}, 32'd1);
        check("tad_pc", {20'b0, PC_value}, 32'o0201);
        check("tad_reads", rd_cnt - r0, 32'd1);
        check("tad_writes", wr_cnt - w0, 32'd0);

        // ISZ on current page rolls 7777 over and skips
        poke(12'o0210, 12'o7777);
        w0 = wr_cnt;
        run(12'o0205, mk_mem(2, 9'o210), '0, "idle_isz");
        check("isz_wr_cnt", wr_cnt - w0, 32'd1);
        check("isz_wr_addr", {20'b0, last_wr_addr}, 32'o0210);
        check("isz_mem", {20'b0, mem[12'o0210]}, 32'd0);
        check("isz_pc", {20'b0, PC_value}, 32'o0207);

        // JMS indirect through 0020
        poke(12'o0020, 12'o0300);
        r0 = rd_cnt; w0 = wr_cnt;
        run(12'o0200, mk_mem(4, 9'o420), '0, "idle_jms");
        check("jms_reads", rd_cnt - r0, 32'd1);
        check("jms_rd_addr", {20'b0, last_rd_addr}, 32'o0020);
        check("jms_wr_addr", {20'b0, last_wr_addr}, 32'o0300);
        check("jms_mem", {20'b0, mem[12'o0300]}, 32'o0201);
        check("jms_wr_stall", {31'b0, wr_stall}, 32'd1);
        check("jms_pc", {20'b0, PC_value}, 32'o0301);
        check("jms_writes", wr_cnt - w0, 32'd1);

        // Operate only: no memory traffic
        r0 = rd_cnt; w0 = wr_cnt;
        run(12'o0301, '0, O_CLA_CLL, "idle_cla_cll2");
        run(12'o0302, '0, O_IAC, "idle_iac");
        check("iac_ac", {20'b0, ac_out}, 32'd1);
        check("iac_link", {31'b0, link_out}, 32'd0);
        check("op7_mem_traffic", (rd_cnt - r0) + (wr_cnt - w0), 32'd0);
        check("iac_pc", {20'b0, PC_value}, 32'o0303);

        // DCA to zero page, then AND after AC=7777
        run(12'o0400, mk_mem(3, 9'o060), '0, "idle_dca");
        check("dca_mem", {20'b0, mem[12'o0060]}, 32'd1);
        check("dca_ac", {20'b0, ac_out}, 32'd0);
        check("dca_pc", {20'b0, PC_value}, 32'o0401);
        run(12'o0401, '0, O_CLA_CLL, "idle_cla_cll3");
        run(12'o0402, '0, O_CMA, "idle_cma2");
        poke(12'o0061, 12'o1234);
        run(12'o0403, mk_mem(0, 9'o061), '0, "idle_and");
        check("and_ac", {20'b0, ac_out}, 32'o1234);
        check("and_pc", {20'b0, PC_value}, 32'o0404);

        // JMP current page, no memory access
        r0 = rd_cnt; w0 = wr_cnt;
        run(12'o0200, mk_mem(5, 9'o377), '0, "idle_jmp");
        check("jmp_pc", {20'b0, PC_value}, 32'o0377);
        check("jmp_mem_traffic", (rd_cnt - r0) + (wr_cnt - w0), 32'd0);

        // Extra dec_valid while the CMA is in EXEC must be dropped
        issue(12'o0500, '0, O_CMA);
        @(negedge clk);
        issue(12'o1000, '0, O_IAC);
        repeat (3) @(negedge clk);
        check("busy_stall", {31'b0, stall}, 32'd0);
        check("busy_ac", {20'b0, ac_out}, 32'o6543);
        check("busy_pc", {20'b0, PC_value}, 32'o0501);

        // HLT holds stall and ignores further decodes
        issue(12'o0501, '0, O_HLT);
        repeat (3) @(negedge clk);
        issue(12'o0600, '0, O_IAC);
        low = 0;
        for (int i = 0; i < 100; i++) begin
            if (stall !== 1'b1) low++;
            @(negedge clk);
        end
        check("halt_stall_low_cycles", low, 32'd0);
        check("halt_ac", {20'b0, ac_out}, 32'o6543);

        // Reset out of HALT, then reset again in the middle of an ISZ read
        reset_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        check("halt_exit_stall", {31'b0, stall}, 32'd0);
        poke(12'o0070, 12'o0005);
        issue(12'o0200, mk_mem(2, 9'o070), '0);
        low = 0;
        while (exec_rd_req !== 1'b1 && low < 10) begin
            @(negedge clk);
            low++;
        end
        check("rst_mid_rd_seen", {31'b0, exec_rd_req}, 32'd1);
        #1 reset_n = 1'b1;
        #1;
        check("rst_mid_pc", {20'b0, PC_value}, 32'o0200);
        check("rst_mid_stall", {31'b0, stall}, 32'd0);
        check("rst_mid_strobes", {30'b0, exec_rd_req, exec_wr_req}, 32'd0);
        @(negedge clk);
        reset_n = 1'b0;
        w0 = wr_cnt;
        repeat (10) @(negedge clk);
        check("rst_mid_no_write", wr_cnt - w0, 32'd0);
        check("rst_mid_mem", {20'b0, mem[12'o0070]}, 32'o0005);

        check("rd_wr_overlap", both_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
